// File: rtl/pic_pkg.sv
// rtl/pic_pkg.sv - shared FSM state type and width helper for the PIC arbiter
package pic_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PRESENT = 2'd1,
      ST_SERVICE = 2'd2
   } pic_state_e;

   // Index width that never collapses to zero for single-entry ranges.
   function automatic int pic_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/pic_arbiter_if.sv
// rtl/pic_arbiter_if.sv - host-side request/ack bus of the PIC arbiter
interface pic_arbiter_if
   import pic_pkg::*;
#(
   parameter int NUM_CH    = 9,
   parameter int NUM_CLASS = 3
);
   localparam int CH_W  = pic_width(NUM_CH);
   localparam int CLS_W = pic_width(NUM_CLASS);

   logic [NUM_CLASS*NUM_CH-1:0] req_i;
   logic [NUM_CH-1:0]           mask_i;
   logic                        ack_i;
   logic                        eoi_i;
   logic                        irq_o;
   logic [CLS_W-1:0]            irq_class_o;
   logic [CH_W-1:0]             irq_chan_o;
   logic                        busy_o;
   logic [NUM_CLASS*NUM_CH-1:0] pend_o;

   modport master (
      output req_i, mask_i, ack_i, eoi_i,
      input  irq_o, irq_class_o, irq_chan_o, busy_o, pend_o
   );

   modport slave (
      input  req_i, mask_i, ack_i, eoi_i,
      output irq_o, irq_class_o, irq_chan_o, busy_o, pend_o
   );

endinterface

// File: rtl/pic_prio_enc.sv
// rtl/pic_prio_enc.sv - fixed-priority encoder: lowest class, then lowest channel wins
module pic_prio_enc
   import pic_pkg::*;
#(
   parameter int NUM_CH    = 9,
   parameter int NUM_CLASS = 3
) (
   input  logic [NUM_CLASS*NUM_CH-1:0]  i_elig,
   output logic                         o_valid,
   output logic [pic_width(NUM_CLASS)-1:0] o_cls,
   output logic [pic_width(NUM_CH)-1:0]    o_chan
);
   localparam int CH_W  = pic_width(NUM_CH);
   localparam int CLS_W = pic_width(NUM_CLASS);

   // Scan from the top down so the lowest flat index is the last writer.
   always_comb begin
      o_valid = 1'b0;
      o_cls   = '0;
      o_chan  = '0;
      for (int c = NUM_CLASS - 1; c >= 0; c--) begin
         for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (i_elig[c*NUM_CH + k]) begin
               o_valid = 1'b1;
               o_cls   = CLS_W'(c);
               o_chan  = CH_W'(k);
            end
         end
      end
   end

endmodule

// File: rtl/pic_arbiter.sv
// rtl/pic_arbiter.sv - sticky pending register and IDLE/PRESENT/SERVICE interrupt FSM
module pic_arbiter
   import pic_pkg::*;
#(
   parameter int NUM_CH    = 9,
   parameter int NUM_CLASS = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   pic_arbiter_if.slave  bus
);
   localparam int CH_W  = pic_width(NUM_CH);
   localparam int CLS_W = pic_width(NUM_CLASS);
   localparam int N     = NUM_CLASS * NUM_CH;
   localparam int IDX_W = pic_width(N);

   pic_state_e       r_state;
   logic [N-1:0]     r_pend;
   logic             r_irq;
   logic             r_busy;
   logic [CLS_W-1:0] r_cls;
   logic [CH_W-1:0]  r_chan;

   logic             w_valid;
   logic [CLS_W-1:0] w_cls;
   logic [CH_W-1:0]  w_chan;
   logic [N-1:0]     w_elig;
   logic [N-1:0]     w_clr;
   logic [IDX_W-1:0] w_idx;
   logic             w_ack_hit;

   assign w_elig    = r_pend & {NUM_CLASS{bus.mask_i}};
   assign w_ack_hit = (r_state == ST_PRESENT) && bus.ack_i;
   assign w_idx     = IDX_W'(r_cls) * IDX_W'(NUM_CH) + IDX_W'(r_chan);
   assign w_clr     = w_ack_hit ? (N'(1) << w_idx) : '0;

   pic_prio_enc #(
      .NUM_CH    (NUM_CH),
      .NUM_CLASS (NUM_CLASS)
   ) u_prio_enc (
      .i_elig  (w_elig),
      .o_valid (w_valid),
      .o_cls   (w_cls),
      .o_chan  (w_chan)
   );

   // A request arriving on the bit being acked keeps it pending.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend <= '0;
      end else begin
         r_pend <= (r_pend & ~w_clr) | bus.req_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_irq   <= 1'b0;
         r_busy  <= 1'b0;
         r_cls   <= '0;
         r_chan  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_valid) begin
                  r_cls   <= w_cls;
                  r_chan  <= w_chan;
                  r_irq   <= 1'b1;
                  r_state <= ST_PRESENT;
               end
            end
            ST_PRESENT: begin
               // Ack beats a same-cycle mask drop; the winner is never re-picked here.
               if (bus.ack_i) begin
                  r_irq   <= 1'b0;
                  r_busy  <= 1'b1;
                  r_state <= ST_SERVICE;
               end else if (!bus.mask_i[r_chan]) begin
                  r_irq   <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
            ST_SERVICE: begin
               if (bus.eoi_i) begin
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_irq   <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.pend_o      = r_pend;
   assign bus.irq_o       = r_irq;
   assign bus.busy_o      = r_busy;
   assign bus.irq_class_o = r_cls;
   assign bus.irq_chan_o  = r_chan;

endmodule

// File: doc/pic_arbiter.md
PIC_ARBITER -- requirements
Module: pic_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 9, number of interrupt channels per class (1..32).
REQ-002 SHALL have parameter NUM_CLASS, default 3, number of request classes (1..4); class 0 is highest priority.
REQ-003 SHALL derive CH_W = max(1, clog2(NUM_CH)) and CLS_W = max(1, clog2(NUM_CLASS)); neither is user-overridable.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_i  input  NUM_CLASS*NUM_CH  level requests; bit c*NUM_CH+k is class c, channel k.
REQ-007 SHALL have port mask_i  input  NUM_CH  per-channel enable; 1 = eligible, applies to all classes.
REQ-008 SHALL have port ack_i  input  1  host accepts the presented interrupt.
REQ-009 SHALL have port eoi_i  input  1  host signals end of service.
REQ-010 SHALL have port irq_o  output  1  interrupt presented.
REQ-011 SHALL have port irq_class_o  output  CLS_W  class of the presented or in-service interrupt.
REQ-012 SHALL have port irq_chan_o  output  CH_W  channel of the presented or in-service interrupt.
REQ-013 SHALL have port busy_o  output  1  high in SERVICE.
REQ-014 SHALL have port pend_o  output  NUM_CLASS*NUM_CH  pending register, same bit mapping as req_i.

Function
REQ-015 SHALL set pend bit b every cycle req_i[b]=1, regardless of mask_i; pend bits are sticky until cleared by ack.
REQ-016 SHALL treat pend bit as eligible when set AND mask_i of its channel = 1.
REQ-017 SHALL select the winner among eligible bits by lowest class, then lowest channel index.
REQ-018 SHALL implement FSM IDLE, PRESENT, SERVICE.
REQ-019 IDLE: if any eligible bit, register winner into irq_class_o/irq_chan_o, go PRESENT; else stay.
REQ-020 PRESENT: irq_o=1; class/chan held stable; winner NOT re-evaluated even if higher-priority bit pends.
REQ-021 PRESENT and ack_i=1: clear the winner pend bit, go SERVICE, irq_o=0 next cycle.
REQ-022 PRESENT and winner channel masked (mask_i=0) without ack_i: go IDLE, pend bit kept, irq_o=0 next cycle; ack_i in the same cycle wins over masking.
REQ-023 SERVICE: busy_o=1, class/chan held; eoi_i=1 goes IDLE; new requests only pend.
REQ-024 SHALL ignore ack_i outside PRESENT and eoi_i outside SERVICE.
REQ-025 SHALL give set priority over clear when req_i and ack-clear hit the same bit in one cycle (bit stays pending).
REQ-026 Latency: req_i high in cycle N with idle FSM -> pend_o set in N+1 -> irq_o high in N+2.
REQ-027 After eoi_i in cycle N, a still-eligible bit SHALL raise irq_o in cycle N+2.
REQ-028 pend_o, irq_o, busy_o, irq_class_o, irq_chan_o SHALL be direct register outputs.

Reset
REQ-029 rst_n=0 SHALL asynchronously force FSM=IDLE, pend=0, irq_o=0, busy_o=0, irq_class_o=0, irq_chan_o=0.
REQ-030 Reset asserted in PRESENT or SERVICE SHALL discard the interrupt; no pend bit survives.
REQ-031 First winner evaluation SHALL occur on the first rising edge after rst_n deasserts.

Structure
REQ-032 Package pic_pkg SHALL hold the FSM state enum and the clog2-based width helper.
REQ-033 Sub-module pic_prio_enc SHALL be the combinational fixed-priority encoder (flat eligible vector in, valid/class/chan out).
REQ-034 pic_arbiter SHALL contain only pend register, FSM and output registers around pic_prio_enc.

Verification
REQ-035 Defaults: one-cycle pulse on req_i[20] (class 2, ch 2), mask all 1s -> irq_o=1 two cycles later, class=2, chan=2; ack -> pend_o=0, busy_o=1; eoi -> IDLE.
REQ-036 Same cycle req_i bits 5 (c0,ch5) and 10 (c1,ch1) -> presented class=0 chan=5; after ack+eoi -> class=1 chan=1.
REQ-037 In PRESENT with c1,ch3, raise req c0,ch0 -> presented stays c1,ch3 until ack; after eoi -> c0,ch0 presented.
REQ-038 Mask ch4 while c0,ch4 presented, no ack -> irq_o=0, pend bit 4 stays 1; unmask -> re-presented in 2 cycles.
REQ-039 req_i[7] held high through ack -> pend bit 7 remains 1; re-presented two cycles after eoi.
REQ-040 rst_n low mid-SERVICE -> all outputs 0 immediately; NUM_CH=32, NUM_CLASS=4 build: req on c3,ch31 only -> class=3, chan=31.
